// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: IO map bit indices, receiver state encoding and helpers shared by the UART RX slice.
package uart_rx_fifo_pkg;
    // These sit next to the existing LEDS/UART_DAT/UART_CNTL word-address bits.
    localparam int IO_UART_RX_DAT_bit    = 3;
    localparam int IO_UART_RX_CNTL_bit   = 4;
    localparam int RX_STAT_VALID_bit     = 8;
    localparam int RX_STAT_OVERRUN_bit   = 10;
    localparam int RX_STAT_FRAME_ERR_bit = 11;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/uart_rx_fifo_rx_byte_fifo.sv
// rx_byte_fifo: receive byte queue; UART_RX_FIFO_EN selects a DEPTH-entry FIFO, otherwise a single holding register.
module rx_byte_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       drop_o
);
    if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 64) begin : g_depth_check
        $error("rx_byte_fifo: DEPTH must be a power of 2 in 2..64");
    end

    logic full, do_push, do_pop;

    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;

    assign valid_o = wr_q != rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{AW{1'b0}}, do_push};
            rd_q <= rd_q + {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end
`else
    logic [7:0] hold_q;
    logic       full_q;

    assign valid_o = full_q;
    assign full    = full_q;
    assign data_o  = hold_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) full_q <= 1'b0;
        else         full_q <= do_push | (full_q & ~do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) hold_q <= data_i;
    end
`endif
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with sticky overrun/frame-error flags feeding rx_byte_fifo.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       i_pop,
    input  logic       i_clr,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overrun,
    output logic       o_frame_err
);
    localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          push_q, push_d, ferr_ev_q, ferr_ev_d;
    logic          ovr_q, ferr_q, drop, cnt_zero;

    assign cnt_zero    = cnt_q == '0;
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ferr_ev_q <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_ev_q <= ferr_ev_d;
            // An error event in the same cycle as a clear wins.
            ovr_q     <= (ovr_q & ~i_clr) | drop;
            ferr_q    <= (ferr_q & ~i_clr) | ferr_ev_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_ev_d = 1'b0;
        case (state_q)
            IDLE: if (prev_q & ~sync2_q) begin
                state_d = START;
                cnt_d   = CW'(CPB / 2);
            end
            START: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else if (sync2_q) state_d = IDLE;
                else begin
                    state_d = DATA;
                    cnt_d   = CW'(CPB - 1);
                    bit_d   = '0;
                end
            DATA: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_d   = CW'(CPB - 1);
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            STOP: if (!cnt_zero) cnt_d = cnt_q - CW'(1);
                else begin
                    state_d   = IDLE;
                    push_d    = sync2_q;
                    ferr_ev_d = ~sync2_q;
                end
            default: state_d = IDLE;
        endcase
    end

    rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (i_pop),
        .data_o  (o_data),
        .valid_o (o_valid),
        .drop_o  (drop)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at 10 MHz / 1 Mbaud with a byte-queue reference for the receive buffer.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CPB = 10;
`ifdef UART_RX_FIFO_EN
    localparam int EFF = 8;
`else
    localparam int EFF = 1;
`endif

    logic       clk = 1'b0, resetn = 1'b0, rxd = 1'b1, i_pop = 1'b0, i_clr = 1'b0;
    logic [7:0] o_data;
    logic       o_valid, o_overrun, o_frame_err;
    logic [7:0] q[$];
    int         n_vec = 0, n_bad = 0;

    always #50 clk = ~clk;

    uart_rx_fifo dut (
        .clk         (clk),
        .resetn      (resetn),
        .rxd         (rxd),
        .i_pop       (i_pop),
        .i_clr       (i_clr),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // act: 0 none, 1 pop, 2 clear, strobed on the edge that pushes (or flags) the byte.
    task automatic send(input logic [7:0] b, input logic stop, input int act, input logic tchk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB - 1) @(negedge clk);
        if (tchk) check("valid_before_push", o_valid, 1'b0);
        i_pop = (act == 1);
        i_clr = (act == 2);
        @(negedge clk);
        i_pop = 1'b0;
        i_clr = 1'b0;
        rxd   = 1'b1;
        if (act == 1 && q.size() > 0) void'(q.pop_front());
        if (stop && q.size() < EFF) q.push_back(b);
        if (tchk) begin
            check("valid_at_push", o_valid, 1'b1);
            check("data_at_push", o_data, b);
        end
    endtask

    task automatic drain(input string tag);
        int exp_n;
        int n;
        logic [7:0] e;
        exp_n = q.size();
        n = 0;
        while (o_valid && n < 70) begin
            e = 8'h00;
            if (q.size() > 0) e = q.pop_front();
            check(tag, o_data, e);
            i_pop = 1'b1;
            @(negedge clk);
            i_pop = 1'b0;
            n++;
        end
        check({tag, "_count"}, n, exp_n);
        check({tag, "_empty"}, o_valid, 1'b0);
    endtask

    task automatic pulse_clr();
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h55, 1'b1, 0, 1'b1);
        i_pop = 1'b1;
        @(negedge clk);
        i_pop = 1'b0;
        void'(q.pop_front());
        check("valid_after_pop", o_valid, 1'b0);
        i_pop = 1'b1;
        @(negedge clk);
        i_pop = 1'b0;
        check("pop_when_empty", o_valid, 1'b0);

        send(8'hA3, 1'b1, 0, 1'b0);
        send(8'h00, 1'b1, 0, 1'b0);
        send(8'hFF, 1'b1, 0, 1'b0);
        check("b2b_overrun", o_overrun, (EFF < 3));
        drain("b2b");
        pulse_clr();

        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 0, 1'b0);
        check("nine_overrun", o_overrun, 1'b1);
        drain("nine");
        pulse_clr();
        check("overrun_cleared", o_overrun, 1'b0);

        send(8'h3C, 1'b0, 2, 1'b0);
        repeat (2) @(negedge clk);
        check("ferr_valid", o_valid, 1'b0);
        check("ferr_set_despite_clr", o_frame_err, 1'b1);
        pulse_clr();
        check("ferr_cleared", o_frame_err, 1'b0);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_valid", o_valid, 1'b0);
        check("glitch_ferr", o_frame_err, 1'b0);

        for (int i = 0; i < EFF; i++) send(8'h10 + 8'(i), 1'b1, 0, 1'b0);
        send(8'h99, 1'b1, 1, 1'b0);
        check("full_pushpop_overrun", o_overrun, 1'b0);
        drain("full_pushpop");

        send(8'h42, 1'b1, 0, 1'b0);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        resetn = 1'b0;
        rxd    = 1'b1;
        #1;
        check("midreset_valid", o_valid, 1'b0);
        q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h7E, 1'b1, 0, 1'b0);
        check("after_reset_data", o_data, 8'h7E);
        drain("after_reset");
        check("after_reset_overrun", o_overrun, 1'b0);
        check("after_reset_ferr", o_frame_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 10000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1000000, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the receive FIFO entry count; it SHALL be a power of 2, range 2..64.
REQ-004 SHALL have port clk, input, width 1: system clock; one clock only.
REQ-005 SHALL have port resetn, input, width 1: asynchronous, active-low reset.
REQ-006 SHALL have port rxd, input, width 1: asynchronous serial line, idle high.
REQ-007 SHALL have port i_pop, input, width 1: single-cycle read strobe that consumes the head entry.
REQ-008 SHALL have port i_clr, input, width 1: single-cycle clear of the sticky error flags.
REQ-009 SHALL have port o_data, output, width 8: the head entry of the FIFO.
REQ-010 SHALL have port o_valid, output, width 1: FIFO not empty.
REQ-011 SHALL have port o_overrun, output, width 1: sticky flag, a byte was dropped because the FIFO was full.
REQ-012 SHALL have port o_frame_err, output, width 1: sticky flag, a stop bit was sampled low.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer, reset value 1, before any use.
REQ-014 SHALL use CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division); elaboration SHALL fail if CLKS_PER_BIT < 4.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP.
REQ-016 IDLE SHALL go to START on a synchronized falling edge, and SHALL load the bit counter with CLKS_PER_BIT/2.
REQ-017 START SHALL re-sample at mid-bit; if the line is low, go to DATA; if high (glitch), return to IDLE with no push.
REQ-018 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT clocks after the previous sample, then go to STOP.
REQ-019 STOP SHALL sample at mid-bit, go to IDLE that same cycle, and on the next clk edge either push the byte (stop bit = 1) or set o_frame_err and discard the byte (stop bit = 0).
REQ-020 o_valid SHALL rise on the clk edge that performs the push.
REQ-021 o_data SHALL be combinational from the head entry and SHALL be stable while o_valid=1 and i_pop=0.
REQ-022 i_pop with o_valid=0 SHALL be ignored; pointers SHALL not move.
REQ-023 A push while full and without a pop in the same cycle SHALL drop the new byte, set o_overrun, and leave the contents unchanged.
REQ-024 A push and a pop in the same cycle SHALL both succeed when full, empty, or partial; an empty FIFO with push and pop SHALL push only.
REQ-025 Pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs equal.
REQ-026 If i_clr and an error event occur in the same cycle, the flag SHALL end up set.

Reset
REQ-027 resetn low SHALL immediately force: state IDLE, both pointers 0, o_valid=0, o_overrun=0, o_frame_err=0, synchronizer=1.
REQ-028 A reset mid-frame SHALL abandon the partial byte; after release, reception SHALL resume only on a new falling edge.
REQ-029 FIFO storage SHALL not require reset; o_data is don't-care while o_valid=0.

Configuration
REQ-030 Macro UART_RX_FIFO_EN defined: FIFO_DEPTH-entry FIFO as specified above.
REQ-031 Macro UART_RX_FIFO_EN undefined: single 8-bit holding register with effective depth 1; FIFO_DEPTH ignored; full/overrun/pop rules unchanged.

Structure
REQ-032 A shared package SHALL hold the IO word-address bit indices (IO_UART_RX_DAT_bit = 3, IO_UART_RX_CNTL_bit = 4) and the status bit positions (valid = bit 8, overrun = bit 10, frame_err = bit 11), so they sit alongside the existing LEDS/UART_DAT/UART_CNTL bits.
REQ-033 The FIFO SHALL be a separate sub-module, rx_byte_fifo, instantiated once; the bit-timing FSM SHALL stay in uart_rx_fifo.

Verification
REQ-034 At 10 MHz and 1 Mbaud, send 0x55 with stop=1 -> o_valid=1 and o_data=0x55 one clk after the stop mid-sample; pop -> o_valid=0.
REQ-035 Send 0xA3, 0x00, 0xFF back-to-back with no pops -> three pops return 0xA3, 0x00, 0xFF in order, and o_overrun=0.
REQ-036 Send 9 bytes (0x01..0x09) at depth 8 with no pops -> pops return 0x01..0x08, o_overrun=1, and i_clr clears it.
REQ-037 Send 0x3C with stop=0 -> o_valid stays 0 and o_frame_err=1; a 3-clk low glitch on rxd -> no push and no error.
REQ-038 Full FIFO with a push and a pop in the same cycle -> count stays 8, no overrun, and the oldest byte is removed.
REQ-039 Assert resetn low during bit 4 of a frame, release it, then send 0x7E -> exactly one entry is received, 0x7E, with no flags.
